// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the RV32I control unit: opcodes,
// scoreboard entry layout, control FSM encoding and a hazard-match helper.
package pipe_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned REG_W  = 5;
  localparam int unsigned OP_W   = 7;
  localparam int unsigned CNT_W  = 32;

  localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OP_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OP_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;

  typedef struct packed {
    logic             vld;
    logic [REG_W-1:0] rd;
  } sb_entry_t;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } ctrl_state_t;

  // True when a used, non-x0 source register matches a live scoreboard entry
  function automatic logic rs_hit(input sb_entry_t e,
                                  input logic use1, input logic [REG_W-1:0] rs1,
                                  input logic use2, input logic [REG_W-1:0] rs2);
    logic m1;
    logic m2;
    m1 = use1 && (rs1 != '0) && (e.rd == rs1);
    m2 = use2 && (rs2 != '0) && (e.rd == rs2);
    return e.vld && (m1 || m2);
  endfunction

endpackage

// File: rtl/rs_use_decode.sv
// Combinational register-usage decode of the instruction sitting in IF/ID.
module rs_use_decode
  import pipe_pkg::*;
(
  input  logic [XLEN-1:0]  instr_id,
  output logic             writes_rd,
  output logic             uses_rs1,
  output logic             uses_rs2,
  output logic [REG_W-1:0] rs1,
  output logic [REG_W-1:0] rs2,
  output logic [REG_W-1:0] rd
);

  logic [OP_W-1:0] opcode;
  logic            unused_fields;

  assign opcode = instr_id[6:0];
  assign rd     = instr_id[11:7];
  assign rs1    = instr_id[19:15];
  assign rs2    = instr_id[24:20];

  // funct3/funct7 play no part in register usage
  assign unused_fields = ^{instr_id[31:25], instr_id[14:12]};

  // Opcode classes that read or write the register file
  always_comb begin
    writes_rd = 1'b0;
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = (opcode != OP_BRANCH) && (opcode != OP_STORE) && (rd != '0);
    uses_rs1  = (opcode != OP_LUI) && (opcode != OP_AUIPC) && (opcode != OP_JAL);
    uses_rs2  = (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
  end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// Hazard/branch control for the non-forwarding five-stage RV32I pipeline.
// Tracks in-flight destinations (EX/MEM/WB), stalls IF/ID on RAW hazards,
// flushes and redirects on taken branches, and counts stalls and flushes.
// Build option: define REGFILE_BYPASS_EN when the register file writes
// before it reads, which drops the WB entry from the hazard compare.
module branch_hazard_ctrl
  import pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_id,
  input  logic        valid_id,
  input  logic        br_taken_ex,
  output logic        stall_if,
  output logic        stall_id,
  output logic        flush_id,
  output logic        bubble_ex,
  output logic        pc_sel,
  output logic [1:0]  ctrl_state,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  logic             writes_rd;
  logic             uses_rs1;
  logic             uses_rs2;
  logic [REG_W-1:0] rs1;
  logic [REG_W-1:0] rs2;
  logic [REG_W-1:0] rd;

  sb_entry_t   sb_ex_q,  sb_ex_d;
  sb_entry_t   sb_mem_q, sb_mem_d;
  sb_entry_t   sb_wb_q,  sb_wb_d;
  logic        ex_vld_q, ex_vld_d;
  ctrl_state_t state_q,  state_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic hazard_c;
  logic taken_c;
  logic hit_ex_c;
  logic hit_mem_c;
  logic hit_wb_c;
  logic stall_c;
  logic flush_c;
  logic bubble_c;
  logic pc_sel_c;

  rs_use_decode u_dec (
    .instr_id  (instr_id),
    .writes_rd (writes_rd),
    .uses_rs1  (uses_rs1),
    .uses_rs2  (uses_rs2),
    .rs1       (rs1),
    .rs2       (rs2),
    .rd        (rd)
  );

  // RAW hazard detect against the live scoreboard entries
  always_comb begin
    hit_ex_c  = rs_hit(sb_ex_q,  uses_rs1, rs1, uses_rs2, rs2);
    hit_mem_c = rs_hit(sb_mem_q, uses_rs1, rs1, uses_rs2, rs2);
`ifdef REGFILE_BYPASS_EN
    hit_wb_c  = 1'b0;
`else
    hit_wb_c  = rs_hit(sb_wb_q,  uses_rs1, rs1, uses_rs2, rs2);
`endif
    hazard_c  = valid_id && (hit_ex_c || hit_mem_c || hit_wb_c);
    taken_c   = br_taken_ex && ex_vld_q;
  end

`ifdef REGFILE_BYPASS_EN
  // WB entry still shifts through but no longer gates issue
  logic unused_wb;
  assign unused_wb = ^sb_wb_q;
`endif

  // Next state, control actions, scoreboard shift and counter updates
  always_comb begin
    state_d     = ST_RUN;
    stall_c     = 1'b0;
    flush_c     = 1'b0;
    bubble_c    = 1'b0;
    pc_sel_c    = 1'b0;
    sb_ex_d     = '0;
    ex_vld_d    = 1'b0;
    sb_mem_d    = sb_ex_q;
    sb_wb_d     = sb_mem_q;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (taken_c) begin
      state_d     = ST_FLUSH;
      flush_c     = 1'b1;
      bubble_c    = 1'b1;
      pc_sel_c    = 1'b1;
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end else if (hazard_c) begin
      state_d     = ST_STALL;
      stall_c     = 1'b1;
      bubble_c    = 1'b1;
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      sb_ex_d.vld = valid_id && writes_rd;
      sb_ex_d.rd  = rd;
      ex_vld_d    = valid_id;
    end
  end

  // Pipeline-tracking registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_ex_q     <= '0;
      sb_mem_q    <= '0;
      sb_wb_q     <= '0;
      ex_vld_q    <= 1'b0;
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      sb_ex_q     <= sb_ex_d;
      sb_mem_q    <= sb_mem_d;
      sb_wb_q     <= sb_wb_d;
      ex_vld_q    <= ex_vld_d;
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Outputs forced quiet while reset is held
  assign stall_if   = ~rst & stall_c;
  assign stall_id   = ~rst & stall_c;
  assign flush_id   = ~rst & flush_c;
  assign bubble_ex  = ~rst & bubble_c;
  assign pc_sel     = ~rst & pc_sel_c;
  assign ctrl_state = rst ? 2'd0 : 2'(state_q);
  assign stall_cnt  = rst ? '0 : stall_cnt_q;
  assign flush_cnt  = rst ? '0 : flush_cnt_q;

endmodule
